// File: rtl/link_frame_ctrl.sv
// Frame sequencer between the processing core and a byte-wide UART.
// TX splits a word into bytes MSB-first over a ready/load handshake; RX packs bytes with an inter-byte timeout.
module link_frame_ctrl #(
  parameter int NBYTES  = 10,
  parameter int TIMEOUT = 50000
) (
  input  logic                  msclk,
  input  logic                  rst,
  input  logic                  send_req,
  input  logic [8*NBYTES-1:0]   tx_msg,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic                  tx_busy,
  output logic                  tx_done,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_strobe,
  output logic [8*NBYTES-1:0]   rx_msg,
  output logic                  rx_valid,
  output logic                  rx_err
);
  localparam int W  = 8*NBYTES;
  localparam int IW = $clog2(NBYTES+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} tx_state_t;

  tx_state_t      st, st_nx;
  logic [W-1:0]   tx_sh, pend_msg;
  logic           pend, fin, done_q;
  logic [IW-1:0]  idx;
  logic [7:0]     byte_hold;

  always_comb begin
    st_nx   = st;
    tx_load = 1'b0;
    fin     = 1'b0;
    case (st)
      IDLE:  if (pend || send_req) st_nx = SEND;
      SEND:  if (tx_ready) begin
               tx_load = 1'b1;
               st_nx   = ACK;
             end
      ACK:   if (!tx_ready) st_nx = DRAIN;
      DRAIN: if (tx_ready) begin
               if (idx == IW'(NBYTES)) begin
                 fin   = 1'b1;
                 st_nx = IDLE;
               end else st_nx = SEND;
             end
      default: st_nx = IDLE;
    endcase
  end

  // Outside SEND the last presented byte is held so the UART never sees a glitch.
  assign tx_byte = (st == SEND) ? tx_sh[W-1 -: 8] : byte_hold;
  assign tx_busy = (st != IDLE);
  assign tx_done = done_q;

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      tx_sh     <= '0;
      pend      <= 1'b0;
      pend_msg  <= '0;
      idx       <= '0;
      byte_hold <= '0;
      done_q    <= 1'b0;
    end else begin
      st     <= st_nx;
      done_q <= fin;
      if (st == SEND) byte_hold <= tx_sh[W-1 -: 8];
      if (st == ACK && !tx_ready) begin
        tx_sh <= tx_sh << 8;
        idx   <= idx + 1'b1;
      end
      // A queued word launches first; a request arriving alongside it takes the pending slot.
      if (st == IDLE) begin
        if (pend) begin
          tx_sh <= pend_msg;
          idx   <= '0;
          pend  <= send_req;
          if (send_req) pend_msg <= tx_msg;
        end else if (send_req) begin
          tx_sh <= tx_msg;
          idx   <= '0;
        end
      end else if (send_req) begin
        pend     <= 1'b1;
        pend_msg <= tx_msg;
      end
    end
  end

  logic [W-1:0]  rx_sh;
  logic [IW-1:0] rcnt;
  logic [TW-1:0] timer;

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      rx_sh    <= '0;
      rcnt     <= '0;
      timer    <= '0;
      rx_msg   <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (rx_strobe) begin
        rx_sh <= {rx_sh[W-9:0], rx_byte};
        timer <= '0;
        if (rcnt == IW'(NBYTES-1)) begin
          rx_msg   <= {rx_sh[W-9:0], rx_byte};
          rx_valid <= 1'b1;
          rcnt     <= '0;
        end else rcnt <= rcnt + 1'b1;
      end else if (rcnt != '0) begin
        // Partial frame gone stale: drop it, leave rx_msg untouched.
        if (timer == TW'(TIMEOUT-1)) begin
          rcnt   <= '0;
          timer  <= '0;
          rx_err <= 1'b1;
        end else timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_link_frame_ctrl.sv
// Directed bench for link_frame_ctrl: queue-based frame model, stub UART, per-cycle compare.
module tb_link_frame_ctrl;
  localparam int NB = 10;
  localparam int TO = 300;

  logic        msclk, rst, send_req, tx_ready, tx_load, tx_busy, tx_done;
  logic        rx_strobe, rx_valid, rx_err;
  logic [79:0] tx_msg, rx_msg;
  logic [7:0]  tx_byte, rx_byte;

  link_frame_ctrl #(.NBYTES(NB), .TIMEOUT(TO)) dut (
    .msclk(msclk), .rst(rst), .send_req(send_req), .tx_msg(tx_msg),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_load(tx_load),
    .tx_busy(tx_busy), .tx_done(tx_done), .rx_byte(rx_byte),
    .rx_strobe(rx_strobe), .rx_msg(rx_msg), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  initial begin
    msclk = 1'b0;
    forever #5 msclk = ~msclk;
  end

  int errors = 0, checks = 0;
  int n_loads = 0, n_done = 0, n_valid = 0, n_err = 0, since = 0;
  logic [7:0]  exp_bytes[$], tx_log[$], rxq[$];
  logic [79:0] exp_msg = '0;
  logic        exp_valid = 1'b0, exp_err = 1'b0;
  int          gap = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame-level model: bytes queued MSB-first, RX frame closes on the NB-th byte or after TO idle cycles.
  always @(posedge msclk) begin
    if (rst) begin
      exp_bytes.delete(); rxq.delete();
      gap = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_msg = '0;
    end else begin
      exp_valid = 1'b0; exp_err = 1'b0;
      if (send_req)
        for (int i = 0; i < NB; i++) exp_bytes.push_back(tx_msg[79-8*i -: 8]);
      if (rx_strobe) begin
        rxq.push_back(rx_byte);
        gap = 0;
        if (rxq.size() == NB) begin
          exp_msg = '0;
          foreach (rxq[i]) exp_msg = {exp_msg[71:0], rxq[i]};
          exp_valid = 1'b1;
          rxq.delete();
        end
      end else if (rxq.size() != 0) begin
        gap++;
        if (gap == TO) begin
          rxq.delete(); gap = 0; exp_err = 1'b1;
        end
      end
    end
  end

  always @(negedge msclk) begin
    if (rst) begin
      chk("reset_tx_outs", {68'd0, tx_byte, tx_load, tx_busy, tx_done, 1'b0}, '0);
      chk("reset_rx_outs", {rx_valid, rx_err}, '0);
      chk("reset_rx_msg", rx_msg, '0);
      since = 0;
    end else begin
      chk("rx_valid", rx_valid, exp_valid);
      chk("rx_err", rx_err, exp_err);
      chk("rx_msg", rx_msg, exp_msg);
      if (rx_valid) n_valid++;
      if (rx_err) n_err++;
      if (tx_load) begin
        chk("load_while_ready", tx_ready, 1'b1);
        if (exp_bytes.size() == 0) chk("tx_extra_load", 1'b1, 1'b0);
        else chk("tx_byte", tx_byte, exp_bytes.pop_front());
        tx_log.push_back(tx_byte);
        n_loads++; since++;
      end
      if (tx_done) begin
        chk("bytes_per_frame", since, NB);
        chk("busy_at_done", tx_busy, 1'b0);
        n_done++; since = 0;
      end
    end
  end

  // Stub UART: ready drops the cycle after a load, returns 20 cycles later.
  logic ld_seen = 1'b0;
  int   ucnt = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge msclk) ld_seen = tx_load && !rst;
      @(posedge msclk); #2;
      if (rst) begin tx_ready = 1'b1; ucnt = 0; end
      else if (ld_seen) begin tx_ready = 1'b0; ucnt = 20; end
      else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [79:0] w);
    @(posedge msclk); #2 send_req = 1'b1; tx_msg = w;
    @(posedge msclk); #2 send_req = 1'b0;
  endtask

  task automatic rx_bytes(input logic [79:0] w, input int n, input int sp);
    for (int i = 0; i < n; i++) begin
      @(posedge msclk); #2 rx_strobe = 1'b1; rx_byte = w[79-8*i -: 8];
      @(posedge msclk); #2 rx_strobe = 1'b0;
      repeat (sp) @(posedge msclk);
    end
  endtask

  task automatic wait_done(input int k);
    int b = 0;
    while (n_done < k && b < 5000) begin @(posedge msclk); b++; end
    chk("tx_done_wait", n_done, k);
  endtask

  task automatic wait_loads(input int k);
    int b = 0;
    while (n_loads < k && b < 2000) begin @(posedge msclk); b++; end
    chk("tx_load_wait", n_loads, k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [79:0] W1 = 80'h0102030405060708090A;
  localparam logic [79:0] WR = 80'h4142434445464748494A;
  localparam logic [79:0] W3 = 80'hA0B1C2D3E4F5061728FF;
  localparam logic [79:0] WA = 80'h11223344556677889900;
  localparam logic [79:0] WB = 80'hCAFEBABEDEADBEEF0F1E;
  localparam logic [79:0] WD = 80'h00FF00FF00FF00FF00FF;
  localparam logic [79:0] WE = 80'h8001_7F02_FE03_5AA5_C33C;

  initial begin
    int base;
    rst = 1'b1; send_req = 1'b0; tx_msg = '0; rx_strobe = 1'b0; rx_byte = '0;
    repeat (3) @(posedge msclk);
    #2 rst = 1'b0;
    @(negedge msclk);
    chk("post_reset_busy", tx_busy, 1'b0);
    chk("post_reset_rx_msg", rx_msg, '0);

    // 1: single TX frame
    send(W1);
    wait_done(1);
    chk("t1_loads", n_loads, 10);
    chk("t1_first_byte", tx_log[0], 8'h01);
    chk("t1_last_byte", tx_log[9], 8'h0A);

    // 2: single RX frame
    rx_bytes(WR, NB, 2);
    repeat (3) @(posedge msclk);
    chk("t2_rx_msg", rx_msg, WR);
    chk("t2_valid_cnt", n_valid, 1);
    chk("t2_err_cnt", n_err, 0);

    // 3: partial frame times out, next frame intact
    rx_bytes(W3, 4, 1);
    repeat (TO + 5) @(posedge msclk);
    chk("t3_err_cnt", n_err, 1);
    chk("t3_valid_cnt", n_valid, 1);
    chk("t3_msg_held", rx_msg, WR);
    rx_bytes(W3, NB, 0);
    repeat (3) @(posedge msclk);
    chk("t3_rx_msg", rx_msg, W3);

    // 4: second request while first frame in flight
    base = n_loads;
    send(WA);
    wait_loads(base + 3);
    send(WB);
    wait_done(3);
    chk("t4_loads", n_loads - base, 20);
    chk("t4_b_first", tx_log[base + 10], 8'hCA);

    // 5: reset during byte 5 of both directions
    base = n_loads;
    send(WD);
    rx_bytes(WE, 4, 5);
    wait_loads(base + 5);
    @(posedge msclk); #2 rst = 1'b1;
    repeat (2) @(posedge msclk);
    #2 rst = 1'b0;
    repeat (2) @(posedge msclk);
    chk("t5_no_done", n_done, 3);
    chk("t5_msg_cleared", rx_msg, '0);

    // 6: full duplex after reset
    fork
      begin send(WD); wait_done(4); end
      rx_bytes(WE, NB, 7);
    join
    repeat (3) @(posedge msclk);
    chk("t6_rx_msg", rx_msg, WE);
    chk("t6_last_tx", tx_log[tx_log.size()-1], 8'hFF);
    chk("model_drained", exp_bytes.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
